// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding, RV32I funct3 codes and fault rule for the data-memory controller.
package mem_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Rejects bad width codes, misaligned halfwords/words and addresses past the end of memory.
  function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] limit);
    logic bad_code, misalign;
    bad_code = we ? (f3 > F3_W) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misalign = ((f3 == F3_H || f3 == F3_HU) && addr[0]) ||
               ((f3 == F3_W) && (addr[1:0] != 2'b00));
    return bad_code || misalign || (addr >= limit);
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte/halfword lane handling: extract and extend load data, merge store data into a word.
module lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    sel_b = rd_word[{byte_off, 3'b000} +: 8];
    sel_h = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
      F3_BU:   load_data = {24'h0, sel_b};
      F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
      F3_HU:   load_data = {16'h0, sel_h};
      default: load_data = rd_word;
    endcase
  end

  // Overlay right-aligned store data onto the previously read word (read-modify-write).
  always_comb begin
    store_word = merge_word;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a core and a word-wide, async-read data memory.
// Sub-word stores are done as read-modify-write; every access ends in a one-cycle response.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * ADDR_WORDS);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        req_fault;
  logic [31:0] load_data, store_word;

  lane_align u_lane (
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .rd_word    (mem_rd),
    .merge_word (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_fault = access_fault(req_we, req_funct3, req_addr, ADDR_LIMIT);

  // Next-state and capture logic for the access sequence.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          fault_d = req_fault;
          rdata_d = 32'h0;  // stores and faults answer with zero data
          if (req_fault)              state_d = ST_RESP;
          else if (!req_we)           state_d = ST_LOAD;
          else if (req_funct3 == F3_W) state_d = ST_WRITE;
          else                        state_d = ST_READ;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_READ: begin
        merge_d = mem_rd;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q & rsp_valid;
  // rst_n gating keeps the memory from committing on an edge where reset is sampled.
  assign mem_we    = (state_q == ST_WRITE) & rst_n;
  assign mem_a     = {addr_q[31:2], 2'b00};
  assign mem_wd    = store_word;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 128-word async-read memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_fault, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [128];
  logic        pk_we = 1'b0;
  logic [6:0]  pk_idx = 7'd0;
  logic [31:0] pk_val = 32'h0;

  int n_chk = 0, n_fail = 0;

  // per-operation observations
  int          r_rsp_at, r_rsp_cnt, r_we_at, r_we_cnt;
  logic [31:0] r_rdata, r_wd, r_wa;
  logic        r_fault;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WORDS(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[8:2]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_a[8:2]] <= mem_wd;
    else if (pk_we) mem[pk_idx] <= pk_val;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [6:0] idx, input logic [31:0] val);
    @(negedge clk);
    pk_we = 1'b1; pk_idx = idx; pk_val = val;
    @(negedge clk);
    pk_we = 1'b0;
  endtask

  // Present one request in an IDLE cycle, then watch 6 cycles after acceptance.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    r_rsp_at = 0; r_rsp_cnt = 0; r_we_at = 0; r_we_cnt = 0;
    r_rdata = 32'hDEAD_BEEF; r_fault = 1'bx; r_wd = 32'h0; r_wa = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        r_rsp_cnt++; r_rsp_at = k; r_rdata = rsp_rdata; r_fault = rsp_fault;
      end
      if (mem_we) begin
        r_we_cnt++; r_we_at = k; r_wd = mem_wd; r_wa = mem_a;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_f, input int exp_at);
    run_op(1'b0, f3, a, 32'h0);
    check({tag, "_at"},    r_rsp_at, exp_at);
    check({tag, "_cnt"},   r_rsp_cnt, 1);
    check({tag, "_rdata"}, r_rdata, exp_d);
    check({tag, "_fault"}, {31'h0, r_fault}, {31'h0, exp_f});
    check({tag, "_nowe"},  r_we_cnt, 0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_we_at, input logic [31:0] exp_wd,
                          input int exp_at);
    run_op(1'b1, f3, a, wd);
    check({tag, "_at"},     r_rsp_at, exp_at);
    check({tag, "_rdata"},  r_rdata, 32'h0);
    check({tag, "_fault"},  {31'h0, r_fault}, 32'h0);
    check({tag, "_wecnt"},  r_we_cnt, 1);
    check({tag, "_weat"},   r_we_at, exp_we_at);
    check({tag, "_wd"},     r_wd, exp_wd);
    check({tag, "_wa"},     r_wa, {a[31:2], 2'b00});
  endtask

  task automatic do_fault_store(input string tag, input logic [2:0] f3, input logic [31:0] a);
    run_op(1'b1, f3, a, 32'hFFFF_FFFF);
    check({tag, "_at"},    r_rsp_at, 1);
    check({tag, "_fault"}, {31'h0, r_fault}, 32'h1);
    check({tag, "_rdata"}, r_rdata, 32'h0);
    check({tag, "_nowe"},  r_we_cnt, 0);
  endtask

  initial begin
    int rsp_seen, we_seen, rdy_first;
    logic [31:0] rsp_d [2];
    int rsp_k [2];

    // reset with memory preload
    poke(7'd0,   32'h1122_3344);
    poke(7'd1,   32'h8899_AABB);
    poke(7'd127, 32'h0BAD_F00D);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rspv",  {31'h0, rsp_valid}, 32'h0);
    check("rst_fault", {31'h0, rsp_fault}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_we",    {31'h0, mem_we}, 32'h0);
    check("rst_mema",  mem_a, 32'h0);
    rst_n = 1'b1;

    // loads with extension
    do_load("lb5",   3'd0, 32'h5, 32'hFFFF_FFAA, 1'b0, 2);
    do_load("lbu5",  3'd4, 32'h5, 32'h0000_00AA, 1'b0, 2);
    do_load("lb7",   3'd0, 32'h7, 32'hFFFF_FF88, 1'b0, 2);
    do_load("lh6",   3'd1, 32'h6, 32'hFFFF_8899, 1'b0, 2);
    do_load("lhu6",  3'd5, 32'h6, 32'h0000_8899, 1'b0, 2);
    do_load("lh4",   3'd1, 32'h4, 32'hFFFF_AABB, 1'b0, 2);
    do_load("lw4",   3'd2, 32'h4, 32'h8899_AABB, 1'b0, 2);
    do_load("lwtop", 3'd2, 32'h1FC, 32'h0BAD_F00D, 1'b0, 2);
    check("mema_hold", mem_a, 32'h1FC);

    // stores: read-modify-write for SB/SH, direct for SW
    do_store("sb6", 3'd0, 32'h6, 32'h1234_5677, 2, 32'h8877_AABB, 3);
    do_load("lw4b", 3'd2, 32'h4, 32'h8877_AABB, 1'b0, 2);
    do_store("sh2", 3'd1, 32'h2, 32'hABCD_BEEF, 2, 32'hBEEF_3344, 3);
    do_load("lw0", 3'd2, 32'h0, 32'hBEEF_3344, 1'b0, 2);
    do_store("sw8", 3'd2, 32'h8, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 2);
    do_load("lw8", 3'd2, 32'h8, 32'hCAFE_F00D, 1'b0, 2);

    // faults
    do_load("lw6f",  3'd2, 32'h6,   32'h0, 1'b1, 1);
    do_load("lh5f",  3'd1, 32'h5,   32'h0, 1'b1, 1);
    do_load("ld3f",  3'd3, 32'h4,   32'h0, 1'b1, 1);
    do_load("ld7f",  3'd7, 32'h4,   32'h0, 1'b1, 1);
    do_load("lw200", 3'd2, 32'h200, 32'h0, 1'b1, 1);
    do_fault_store("sw200", 3'd2, 32'h200);
    do_fault_store("st4f",  3'd4, 32'h4);
    do_fault_store("sh7f",  3'd1, 32'h7);
    check("mem1_kept", mem[1], 32'h8877_AABB);

    // reset while in READ (SH 0x4): access abandoned
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h4; req_wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstrd_ready", {31'h0, req_ready}, 32'h1);
    rsp_seen = 0; we_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) rsp_seen++;
      if (mem_we) we_seen++;
      @(negedge clk);
    end
    check("rstrd_norsp", rsp_seen, 0);
    check("rstrd_nowe",  we_seen, 0);
    check("rstrd_mem",   mem[1], 32'h8877_AABB);

    // reset asserted during WRITE (SB 0x4): write must be suppressed
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h4; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstwr_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstwr_ready", {31'h0, req_ready}, 32'h1);
    check("rstwr_rspv",  {31'h0, rsp_valid}, 32'h0);
    check("rstwr_mem",   mem[1], 32'h8877_AABB);

    // req_valid held high: LW 0x4 then LW 0x0
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4;
    @(posedge clk);
    rsp_seen = 0; rdy_first = 0; rsp_d[0] = 0; rsp_d[1] = 0; rsp_k[0] = 0; rsp_k[1] = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_addr = 32'h0;
      if (k == 4) req_valid = 1'b0;
      if (req_ready && rdy_first == 0) rdy_first = k;
      if (rsp_valid) begin
        if (rsp_seen < 2) begin
          rsp_d[rsp_seen] = rsp_rdata; rsp_k[rsp_seen] = k;
        end
        rsp_seen++;
      end
    end
    check("b2b_accept", rdy_first, 3);
    check("b2b_nrsp",   rsp_seen, 2);
    check("b2b_at0",    rsp_k[0], 2);
    check("b2b_at1",    rsp_k[1], 5);
    check("b2b_d0",     rsp_d[0], 32'h8877_AABB);
    check("b2b_d1",     rsp_d[1], 32'hBEEF_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
